// File: rtl/hilo_issue_ctrl.sv
// rtl/hilo_issue_ctrl.sv - E-stage HI/LO multiply-divide issue, latency count and stall control
module hilo_issue_ctrl #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             e_valid,
   input  logic [3:0]       e_hilo_op,
   input  logic             d_uses_hilo,
   input  logic             cancel,
   output logic             start_o,
   output logic [1:0]       op_o,
   output logic             wr_hi_o,
   output logic             wr_lo_o,
   output logic             commit_o,
   output logic             busy_o,
   output logic             d_stall_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             err_o
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             err;
   logic             run;
   logic             md;
   logic             hilo_any;
   logic             is_mul;

   assign run      = (state == RUN);
   assign md       = e_valid & (e_hilo_op >= 4'd1) & (e_hilo_op <= 4'd4);
   assign hilo_any = e_valid & (e_hilo_op >= 4'd1) & (e_hilo_op <= 4'd8);
   assign is_mul   = (e_hilo_op == 4'd1) | (e_hilo_op == 4'd2);

   // Every output is forced low while reset is held, including the combinational strobes.
   assign start_o   = ~reset & ~run & md & ~cancel;
   assign op_o      = start_o ? (e_hilo_op[1:0] - 2'd1) : 2'd0;
   assign wr_hi_o   = ~reset & ~run & e_valid & (e_hilo_op == 4'd7) & ~cancel;
   assign wr_lo_o   = ~reset & ~run & e_valid & (e_hilo_op == 4'd8) & ~cancel;
   assign commit_o  = ~reset & run & (cnt == CNT_W'(1)) & ~cancel;
   assign busy_o    = ~reset & (start_o | run);
   assign d_stall_o = d_uses_hilo & busy_o;
   assign cnt_o     = reset ? '0 : cnt;
   assign err_o     = ~reset & err;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         if (run && hilo_any)
            err <= 1'b1;
         case (state)
            IDLE: begin
               if (start_o) begin
                  cnt   <= is_mul ? MUL_CNT : DIV_CNT;
                  state <= RUN;
               end
            end
            RUN: begin
               // Cancel and completion both return to IDLE; only completion commits.
               if (cancel || cnt <= CNT_W'(1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// tb/tb_hilo_issue_ctrl.sv - directed self-checking bench for hilo_issue_ctrl
module tb_hilo_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       e_valid;
   logic [3:0] e_hilo_op;
   logic       d_uses_hilo;
   logic       cancel;
   logic       start_o;
   logic [1:0] op_o;
   logic       wr_hi_o;
   logic       wr_lo_o;
   logic       commit_o;
   logic       busy_o;
   logic       d_stall_o;
   logic [3:0] cnt_o;
   logic       err_o;

   int vectors = 0;
   int miscompares = 0;

   hilo_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_hilo_op(e_hilo_op),
      .d_uses_hilo(d_uses_hilo), .cancel(cancel), .start_o(start_o), .op_o(op_o),
      .wr_hi_o(wr_hi_o), .wr_lo_o(wr_lo_o), .commit_o(commit_o), .busy_o(busy_o),
      .d_stall_o(d_stall_o), .cnt_o(cnt_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive just after the edge, leave the caller to sample mid-cycle.
   task automatic cyc(input logic rst, input logic v, input logic [3:0] op,
                      input logic du, input logic cn);
      @(posedge clk);
      #1;
      reset = rst; e_valid = v; e_hilo_op = op; d_uses_hilo = du; cancel = cn;
      #3;
   endtask

   initial begin
      reset = 1'b1; e_valid = 1'b0; e_hilo_op = 4'd0; d_uses_hilo = 1'b0; cancel = 1'b0;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 0);
      chk("rst_start", {7'd0, start_o}, 8'd0);
      chk("rst_busy", {7'd0, busy_o}, 8'd0);
      chk("rst_stall", {7'd0, d_stall_o}, 8'd0);
      chk("rst_cnt", {4'd0, cnt_o}, 8'd0);
      chk("rst_err", {7'd0, err_o}, 8'd0);

      // 1: mult latency
      cyc(0, 1, 1, 0, 0);
      chk("t1_start", {7'd0, start_o}, 8'd1);
      chk("t1_op", {6'd0, op_o}, 8'd0);
      chk("t1_busy0", {7'd0, busy_o}, 8'd1);
      chk("t1_cnt0", {4'd0, cnt_o}, 8'd0);
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 0, 0, 0, 0);
         chk("t1_cnt", {4'd0, cnt_o}, 8'(6 - i));
         chk("t1_busy", {7'd0, busy_o}, 8'd1);
         chk("t1_commit", {7'd0, commit_o}, (i == 5) ? 8'd1 : 8'd0);
      end
      cyc(0, 0, 0, 0, 0);
      chk("t1_busy_end", {7'd0, busy_o}, 8'd0);
      chk("t1_commit_end", {7'd0, commit_o}, 8'd0);

      // 2: divu with D-stage stall
      cyc(0, 1, 4, 1, 0);
      chk("t2_start", {7'd0, start_o}, 8'd1);
      chk("t2_op", {6'd0, op_o}, 8'd3);
      chk("t2_stall0", {7'd0, d_stall_o}, 8'd1);
      for (int i = 1; i <= 10; i++) begin
         cyc(0, 0, 0, 1, 0);
         chk("t2_stall", {7'd0, d_stall_o}, 8'd1);
         chk("t2_cnt", {4'd0, cnt_o}, 8'(11 - i));
         chk("t2_commit", {7'd0, commit_o}, (i == 10) ? 8'd1 : 8'd0);
      end
      cyc(0, 0, 0, 1, 0);
      chk("t2_stall_end", {7'd0, d_stall_o}, 8'd0);
      chk("t2_cnt_end", {4'd0, cnt_o}, 8'd0);

      // 3: div cancelled at cnt 3, then mult issues next cycle
      cyc(0, 1, 3, 0, 0);
      chk("t3_op", {6'd0, op_o}, 8'd2);
      for (int i = 1; i <= 7; i++) begin
         cyc(0, 0, 0, 0, 0);
         chk("t3_commit", {7'd0, commit_o}, 8'd0);
      end
      cyc(0, 0, 0, 0, 1);
      chk("t3_cnt_cancel", {4'd0, cnt_o}, 8'd3);
      chk("t3_commit_cancel", {7'd0, commit_o}, 8'd0);
      cyc(0, 0, 0, 0, 0);
      chk("t3_busy_after", {7'd0, busy_o}, 8'd0);
      chk("t3_cnt_after", {4'd0, cnt_o}, 8'd0);
      e_valid = 1'b1; e_hilo_op = 4'd1;
      #1;
      chk("t3_restart", {7'd0, start_o}, 8'd1);
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 0, 0, 0, 0);
         chk("t3_mult_commit", {7'd0, commit_o}, (i == 5) ? 8'd1 : 8'd0);
      end

      // 4: mthi/mtlo in IDLE, with and without cancel, and an undefined op
      cyc(0, 1, 7, 1, 0);
      chk("t4_wrhi", {7'd0, wr_hi_o}, 8'd1);
      chk("t4_wrlo", {7'd0, wr_lo_o}, 8'd0);
      chk("t4_busy", {7'd0, busy_o}, 8'd0);
      chk("t4_stall", {7'd0, d_stall_o}, 8'd0);
      cyc(0, 0, 0, 0, 0);
      chk("t4_wrhi_next", {7'd0, wr_hi_o}, 8'd0);
      cyc(0, 1, 7, 0, 1);
      chk("t4_wrhi_cancel", {7'd0, wr_hi_o}, 8'd0);
      cyc(0, 1, 8, 0, 0);
      chk("t4_wrlo", {7'd0, wr_lo_o}, 8'd1);
      cyc(0, 1, 12, 0, 0);
      chk("t4_op12_start", {7'd0, start_o}, 8'd0);
      chk("t4_op12_busy", {7'd0, busy_o}, 8'd0);

      // 5: HILO op during RUN sets sticky err, ignored, commit unaffected
      cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("t5_err_t1", {7'd0, err_o}, 8'd0);
      cyc(0, 1, 6, 0, 0);
      chk("t5_err_t2", {7'd0, err_o}, 8'd0);
      cyc(0, 0, 0, 0, 0);
      chk("t5_err_t3", {7'd0, err_o}, 8'd1);
      cyc(0, 1, 7, 0, 0);
      chk("t5_wrhi_run", {7'd0, wr_hi_o}, 8'd0);
      chk("t5_start_run", {7'd0, start_o}, 8'd0);
      cyc(0, 0, 0, 0, 0);
      chk("t5_commit", {7'd0, commit_o}, 8'd1);
      chk("t5_err_t5", {7'd0, err_o}, 8'd1);
      cyc(0, 0, 0, 0, 0);
      chk("t5_err_t6", {7'd0, err_o}, 8'd1);

      // 6a: reset mid-RUN
      cyc(0, 1, 2, 0, 0);
      chk("t6_op", {6'd0, op_o}, 8'd1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("t6_busy_rst", {7'd0, busy_o}, 8'd0);
      cyc(0, 0, 0, 0, 0);
      chk("t6_busy_t4", {7'd0, busy_o}, 8'd0);
      chk("t6_cnt_t4", {4'd0, cnt_o}, 8'd0);
      chk("t6_err_t4", {7'd0, err_o}, 8'd0);
      chk("t6_commit_t4", {7'd0, commit_o}, 8'd0);
      cyc(0, 0, 0, 0, 0);
      chk("t6_commit_t5", {7'd0, commit_o}, 8'd0);

      // 6b: cancel in the commit cycle wins
      cyc(0, 1, 2, 0, 0);
      for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t6_cnt_due", {4'd0, cnt_o}, 8'd1);
      chk("t6_commit_cancel", {7'd0, commit_o}, 8'd0);
      cyc(0, 0, 0, 0, 0);
      chk("t6_busy_end", {7'd0, busy_o}, 8'd0);
      chk("t6_commit_end", {7'd0, commit_o}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
